pi_loop_scheduler: RTL and testbench
====================================

# pi_loop_scheduler

Sample-rate scheduler for the digital PI loop. It generates a programmable sample tick and starts an ADC conversion on each tick. It then hands the converted sample to the PI controller and loads the resulting control word into the DAC. It sits between the ADC front end, the PI controller and the DAC interface, and detects overruns and stalled handshakes.

## Interface
- DIV_W, 16: width of the sample-period divider.
- TIMEOUT, 255: maximum cycles spent waiting for any handshake response.
- CNT_W, 8: width of the overrun counter.

- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- enable  in  1  loop run enable
- sample_div  in  DIV_W  sample period minus one, in clk cycles
- clear_err  in  1  clears timeout_err and overrun_cnt
- adc_start  out  1  one-cycle conversion request
- adc_done  in  1  one-cycle conversion-complete pulse
- pi_start  out  1  one-cycle PI computation request
- pi_done  in  1  one-cycle PI completion pulse
- pi_u  in  16  signed PI control output, valid with pi_done
- dac_ready  in  1  DAC interface can accept a word
- dac_load  out  1  one-cycle DAC load strobe
- dac_data  out  16  signed word captured from pi_u
- busy  out  1  high while a loop cycle is in progress
- overrun_cnt  out  CNT_W  saturating count of dropped ticks
- timeout_err  out  1  sticky handshake timeout flag

## Operation
- **Reset values.** All outputs reset to 0. The state resets to IDLE, and the divider and watchdog reset to 0.
- **Divider.**
  - Counts while enable=1 and is forced to 0 while enable=0.
  - When count >= sample_div, it asserts tick for one cycle and reloads to 0. Period is therefore sample_div+1 cycles.
  - sample_div=0 gives a tick every cycle.
- **States and transitions.**
  - IDLE -> WAIT_TICK when enable=1.
  - WAIT_TICK -> IDLE when enable=0. Otherwise -> ADC_REQ on tick.
  - ADC_REQ asserts adc_start, then -> ADC_WAIT.
  - ADC_WAIT -> PI_REQ on adc_done.
  - PI_REQ asserts pi_start, then -> PI_WAIT.
  - PI_WAIT: on pi_done, capture pi_u into a holding register, then -> DAC_WAIT.
  - DAC_WAIT -> DAC_LOAD when dac_ready=1.
  - DAC_LOAD asserts dac_load with dac_data = held word, then -> WAIT_TICK if enable=1, else IDLE.
- **Registered outputs.** adc_start, pi_start and dac_load are registered state decodes, high for exactly one cycle per visit. dac_data changes only in the DAC_LOAD cycle and holds otherwise.
- **busy.** busy=1 in every state except IDLE and WAIT_TICK.
- **Overrun.**
  - A tick in any state other than WAIT_TICK is dropped and increments overrun_cnt.
  - overrun_cnt saturates at 2^CNT_W-1.
  - The current cycle is not disturbed.
- **Watchdog.**
  - Cleared on entry to ADC_WAIT, PI_WAIT or DAC_WAIT, and incremented each cycle spent there.
  - If the awaited event has not arrived by the cycle where the watchdog equals TIMEOUT-1, the cycle aborts: timeout_err is set, no dac_load is issued, and the next state is WAIT_TICK (IDLE if enable=0).
  - An event arriving in the expiry cycle wins: no timeout.
- **Enable deassert mid-cycle.** The current cycle runs to completion, including dac_load; the block then goes to IDLE.
- **clear_err.** Clears timeout_err and overrun_cnt. Clear wins over a simultaneous set or increment.
- **Stray pulses.** adc_done and pi_done outside their wait states are ignored.
- **Reset mid-operation.** Asynchronously returns all state and outputs to reset values immediately. No partial strobe completes.

## Timing
- Tick in WAIT_TICK at cycle T -> adc_start high at T+1.
- adc_done at cycle A (in ADC_WAIT) -> pi_start at A+1.
- pi_done at cycle P (in PI_WAIT) -> DAC_WAIT at P+1.
- dac_ready at cycle D (in DAC_WAIT) -> dac_load at D+1, WAIT_TICK at D+2.
- Zero-latency responders give a minimum loop of 7 cycles, tick to next WAIT_TICK:
  - adc_done at T+2, pi_done at T+4, dac_ready at T+5 -> dac_load at T+6, WAIT_TICK at T+7.
  - sample_div >= 6 therefore produces no overrun with zero-latency responders.
- The timeout aborts TIMEOUT cycles after entering the wait state; WAIT_TICK (or IDLE) is reached on the following cycle.
- Rising enable at cycle E -> WAIT_TICK at E+1. The first tick comes sample_div+1 cycles after the divider starts counting.

## Test plan
- **Nominal loop.** sample_div=9, responders answer in 1 cycle, pi_u=16'h1234 -> adc_start every 10 cycles, dac_load with dac_data=16'h1234 each period, overrun_cnt=0.
- **Overrun.** sample_div=3, same responders -> overrun_cnt increments once per dropped tick; the loop still completes, and the count saturates at 255 with CNT_W=8.
- **Timeout.** adc_done never asserted, TIMEOUT=255 -> timeout_err=1 after 255 cycles in ADC_WAIT, no pi_start, and the next tick restarts with adc_start. Then adc_done in the expiry cycle -> no timeout.
- **DAC backpressure and stray pulses.** dac_ready low for 20 cycles -> dac_load the cycle after dac_ready rises, with data unchanged. A pi_done injected in WAIT_TICK -> ignored.
- **Enable deassert.** Drop enable during PI_WAIT -> the cycle completes with dac_load, then IDLE, busy=0, divider held at 0.
- **Reset and clear.** Assert reset in ADC_WAIT -> all outputs 0 immediately. clear_err coincident with an overrun tick -> overrun_cnt=0.

Source files
------------

// File: rtl/pi_loop_scheduler.sv
// Sample-rate scheduler for the PI loop: divider tick, ADC -> PI -> DAC
// sequencing, handshake watchdog, overrun counting and sticky timeout flag.
//
// Ports:
//   clk, reset     rising-edge clock, async active-high reset
//   enable         loop run enable
//   sample_div     sample period minus one, in clk cycles
//   clear_err      clears timeout_err and overrun_cnt
//   adc_start/done ADC conversion request / completion pulse
//   pi_start/done  PI computation request / completion pulse
//   pi_u           PI control word, valid with pi_done
//   dac_ready      DAC can accept a word
//   dac_load/data  DAC load strobe and held control word
//   busy           a loop cycle is in progress
//   overrun_cnt    saturating count of dropped ticks
//   timeout_err    sticky handshake timeout flag
module pi_loop_scheduler #(
  parameter int DIV_W   = 16,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [DIV_W-1:0] sample_div,
  input  logic             clear_err,
  output logic             adc_start,
  input  logic             adc_done,
  output logic             pi_start,
  input  logic             pi_done,
  input  logic [15:0]      pi_u,
  input  logic             dac_ready,
  output logic             dac_load,
  output logic [15:0]      dac_data,
  output logic             busy,
  output logic [CNT_W-1:0] overrun_cnt,
  output logic             timeout_err
);

  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_TICK,
    ADC_REQ,
    ADC_WAIT,
    PI_REQ,
    PI_WAIT,
    DAC_WAIT,
    DAC_LOAD
  } state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic [15:0]      hold_q, hold_d;
  logic             adc_start_q, adc_start_d;
  logic             pi_start_q, pi_start_d;
  logic             dac_load_q, dac_load_d;
  logic [15:0]      dac_data_q, dac_data_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] ovr_q, ovr_d;
  logic             terr_q, terr_d;

  logic tick;
  logic expired;
  logic abort;
  logic in_wait;

  always_comb begin
    tick    = enable && (div_q >= sample_div);
    div_d   = (!enable || tick) ? '0 : div_q + DIV_W'(1);
    expired = (wd_q == WD_LAST);
    state_d = state_q;
    hold_d  = hold_q;
    abort   = 1'b0;

    unique case (state_q)
      IDLE:      if (enable) state_d = WAIT_TICK;
      WAIT_TICK: begin
        if (!enable)   state_d = IDLE;
        else if (tick) state_d = ADC_REQ;
      end
      ADC_REQ:   state_d = ADC_WAIT;
      ADC_WAIT: begin
        if (adc_done)     state_d = PI_REQ;
        else if (expired) abort = 1'b1;
      end
      PI_REQ:    state_d = PI_WAIT;
      PI_WAIT: begin
        if (pi_done) begin
          hold_d  = pi_u;
          state_d = DAC_WAIT;
        end else if (expired) begin
          abort = 1'b1;
        end
      end
      DAC_WAIT: begin
        if (dac_ready)    state_d = DAC_LOAD;
        else if (expired) abort = 1'b1;
      end
      DAC_LOAD:  state_d = enable ? WAIT_TICK : IDLE;
      default:   state_d = IDLE;
    endcase

    // An arriving event in the expiry cycle takes the normal path above,
    // so abort is only raised when nothing came.
    if (abort) state_d = enable ? WAIT_TICK : IDLE;

    in_wait = (state_q == ADC_WAIT) || (state_q == PI_WAIT) ||
              (state_q == DAC_WAIT);
    wd_d = (in_wait && state_d == state_q) ? wd_q + WD_W'(1) : '0;

    ovr_d = ovr_q;
    if (tick && state_q != WAIT_TICK && ovr_q != '1)
      ovr_d = ovr_q + CNT_W'(1);
    terr_d = terr_q | abort;
    if (clear_err) begin
      ovr_d  = '0;
      terr_d = 1'b0;
    end

    adc_start_d = (state_d == ADC_REQ);
    pi_start_d  = (state_d == PI_REQ);
    dac_load_d  = (state_d == DAC_LOAD);
    dac_data_d  = dac_load_d ? hold_d : dac_data_q;
    busy_d      = !((state_d == IDLE) || (state_d == WAIT_TICK));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      div_q       <= '0;
      wd_q        <= '0;
      hold_q      <= '0;
      adc_start_q <= 1'b0;
      pi_start_q  <= 1'b0;
      dac_load_q  <= 1'b0;
      dac_data_q  <= '0;
      busy_q      <= 1'b0;
      ovr_q       <= '0;
      terr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      wd_q        <= wd_d;
      hold_q      <= hold_d;
      adc_start_q <= adc_start_d;
      pi_start_q  <= pi_start_d;
      dac_load_q  <= dac_load_d;
      dac_data_q  <= dac_data_d;
      busy_q      <= busy_d;
      ovr_q       <= ovr_d;
      terr_q      <= terr_d;
    end
  end

  assign adc_start   = adc_start_q;
  assign pi_start    = pi_start_q;
  assign dac_load    = dac_load_q;
  assign dac_data    = dac_data_q;
  assign busy        = busy_q;
  assign overrun_cnt = ovr_q;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_pi_loop_scheduler.sv
// Randomized bench for pi_loop_scheduler against a behavioural loop model.
// Phases: nominal, overrun/saturation, timeout, expiry race, backpressure.
module tb_pi_loop_scheduler;

  localparam int DIV_W   = 16;
  localparam int TIMEOUT = 255;
  localparam int CNT_W   = 8;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             enable = 1'b0;
  logic [DIV_W-1:0] sample_div = '0;
  logic             clear_err = 1'b0;
  logic             adc_start;
  logic             adc_done = 1'b0;
  logic             pi_start;
  logic             pi_done = 1'b0;
  logic [15:0]      pi_u = '0;
  logic             dac_ready = 1'b0;
  logic             dac_load;
  logic [15:0]      dac_data;
  logic             busy;
  logic [CNT_W-1:0] overrun_cnt;
  logic             timeout_err;

  pi_loop_scheduler #(
    .DIV_W(DIV_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .sample_div(sample_div), .clear_err(clear_err),
    .adc_start(adc_start), .adc_done(adc_done),
    .pi_start(pi_start), .pi_done(pi_done), .pi_u(pi_u),
    .dac_ready(dac_ready), .dac_load(dac_load),
    .dac_data(dac_data), .busy(busy),
    .overrun_cnt(overrun_cnt), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: loop phase, cycle timestamps, plain counters.
  localparam int S_IDLE = 0, S_WT = 1, S_AREQ = 2, S_AWAIT = 3;
  localparam int S_PREQ = 4, S_PWAIT = 5, S_DWAIT = 6, S_DLOAD = 7;

  int          m_st = S_IDLE;
  int          m_div = 0;
  int          m_cyc = 0;
  int          m_entry = 0;
  int          m_ovr = 0;
  bit          m_terr = 0;
  logic [15:0] m_hold = '0;
  logic [15:0] m_data = '0;
  bit          e_adc = 0, e_pi = 0, e_load = 0, e_busy = 0;

  always @(posedge clk or posedge reset) begin
    int nxt;
    bit tk, late, abort;
    if (reset) begin
      m_st = S_IDLE; m_div = 0; m_cyc = 0; m_entry = 0;
      m_ovr = 0; m_terr = 0; m_hold = '0; m_data = '0;
      e_adc = 0; e_pi = 0; e_load = 0; e_busy = 0;
    end else begin
      tk    = enable && (m_div >= int'(sample_div));
      m_div = (enable && !tk) ? m_div + 1 : 0;
      late  = (m_cyc - m_entry) == TIMEOUT - 1;
      abort = 0;
      nxt   = m_st;
      case (m_st)
        S_IDLE:  if (enable) nxt = S_WT;
        S_WT:    nxt = !enable ? S_IDLE : (tk ? S_AREQ : S_WT);
        S_AREQ:  nxt = S_AWAIT;
        S_AWAIT: if (adc_done) nxt = S_PREQ; else abort = late;
        S_PREQ:  nxt = S_PWAIT;
        S_PWAIT:
          if (pi_done) begin m_hold = pi_u; nxt = S_DWAIT; end
          else abort = late;
        S_DWAIT: if (dac_ready) nxt = S_DLOAD; else abort = late;
        default: nxt = enable ? S_WT : S_IDLE;
      endcase
      if (abort) begin
        nxt = enable ? S_WT : S_IDLE;
        m_terr = 1;
      end
      if (tk && m_st != S_WT && m_ovr < 255) m_ovr++;
      if (clear_err) begin m_ovr = 0; m_terr = 0; end
      if (nxt != m_st &&
          (nxt == S_AWAIT || nxt == S_PWAIT || nxt == S_DWAIT))
        m_entry = m_cyc + 1;
      m_cyc++;
      m_st   = nxt;
      e_adc  = (nxt == S_AREQ);
      e_pi   = (nxt == S_PREQ);
      e_load = (nxt == S_DLOAD);
      if (e_load) m_data = m_hold;
      e_busy = !(nxt == S_IDLE || nxt == S_WT);
    end
  end

  task automatic check_outputs();
    chk("adc_start", adc_start, e_adc);
    chk("pi_start", pi_start, e_pi);
    chk("dac_load", dac_load, e_load);
    chk("dac_data", dac_data, m_data);
    chk("busy", busy, e_busy);
    chk("overrun_cnt", overrun_cnt, m_ovr);
    chk("timeout_err", timeout_err, m_terr);
  endtask

  // Stimulus knobs: percent for responders, per-mille for toggles/clears.
  int p_adc, p_pi, p_dac, p_tog, p_clr;
  bit force_exp = 0;
  bit exp_pending = 0;

  task automatic drive();
    adc_done  = ($urandom_range(99) < p_adc);
    pi_done   = ($urandom_range(99) < p_pi);
    dac_ready = ($urandom_range(99) < p_dac);
    pi_u      = 16'($urandom);
    clear_err = ($urandom_range(999) < p_clr);
    if ($urandom_range(999) < p_tog) enable = ~enable;
    if (force_exp && m_st == S_AWAIT &&
        (m_cyc - m_entry) == TIMEOUT - 1) begin
      adc_done    = 1'b1;
      exp_pending = 1;
    end
  endtask

  task automatic run_phase(int div, int pa, int pp, int pd,
                           int tog, int clr, int cycles);
    sample_div = DIV_W'(div);
    p_adc = pa; p_pi = pp; p_dac = pd; p_tog = tog; p_clr = clr;
    enable = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      check_outputs();
      if (exp_pending) begin
        chk("expiry_win_pi_start", pi_start, 1);
        exp_pending = 0;
      end
      drive();
    end
  endtask

  initial begin
    bit reached;
    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    check_outputs();
    reset = 1'b0;

    run_phase(9, 100, 100, 100, 0, 0, 300);
    run_phase(3, 100, 100, 100, 0, 0, 200);
    run_phase(3, 60, 60, 60, 0, 0, 200);
    run_phase(0, 0, 100, 100, 0, 0, 700);
    run_phase(0, 0, 100, 100, 0, 20, 300);
    force_exp = 1;
    run_phase(2, 0, 100, 100, 0, 0, 900);
    force_exp = 0;
    run_phase(40, 100, 100, 5, 0, 0, 400);
    run_phase(25, 80, 10, 30, 30, 0, 600);
    for (int k = 0; k < 6; k++)
      run_phase($urandom_range(30), 40 + $urandom_range(50),
                40 + $urandom_range(50), 30 + $urandom_range(60),
                20, 10, 500);

    // Asynchronous reset while stalled in ADC_WAIT.
    sample_div = 5; enable = 1'b1;
    p_adc = 0; p_pi = 100; p_dac = 100; p_tog = 0; p_clr = 0;
    reached = 0;
    for (int i = 0; i < 200 && !reached; i++) begin
      @(negedge clk);
      check_outputs();
      drive();
      reached = (m_st == S_AWAIT);
    end
    chk("reach_adc_wait", reached, 1);
    @(negedge clk);
    check_outputs();
    reset = 1'b1;
    #1;
    chk("rst_adc_start", adc_start, 0);
    chk("rst_pi_start", pi_start, 0);
    chk("rst_dac_load", dac_load, 0);
    chk("rst_dac_data", dac_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun_cnt, 0);
    chk("rst_timeout", timeout_err, 0);
    @(negedge clk);
    check_outputs();
    reset = 1'b0;
    run_phase(6, 100, 100, 100, 0, 0, 100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
